// File: rtl/dpd_poly_apply.sv
// dpd_poly_apply: applies a 5-term memoryless DPD polynomial
//   y = sum_k c_k * |x|^k * x, k = 0..4
// The sample is aligned to the magnitude powers, then passes four registered
// stages: S1 basis product, S2 basis round, S3 coefficient product, S4 sum.
// Coefficients are written into a shadow bank. coef_commit copies the shadow
// bank into the active bank in one clock edge. S3 is the only stage that
// reads the active bank.
//
// Optional feature: define DPD_POLY_BYPASS_EN to add the `bypass` input.
// When bypass is set at S4, the output is the aligned input sample at the
// same latency.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid              qualifier for sig_in_i/q
//   sig_in_i/q [19:0]     signed Q1.19 input sample
//   mag_0..mag_4 [19:0]   unsigned Q1.19 |x|^k, ALIGN_DLY cycles behind sig_in
//   coef_wr, coef_addr    shadow-bank write strobe and index (0..4 valid)
//   coef_i/q [17:0]       signed Q2.16 coefficient
//   coef_commit           copy shadow bank to active bank
//   bypass                (DPD_POLY_BYPASS_EN only) pass the delayed input
//   out_i/q [19:0]        signed Q1.19 output, registered
//   out_valid, out_sat    output qualifier; S4 clip indicator
//   coef_err              sticky flag for a write with coef_addr > 4
module dpd_poly_apply #(
    parameter int unsigned ALIGN_DLY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [19:0] sig_in_i,
    input  logic [19:0] sig_in_q,
    input  logic [19:0] mag_0,
    input  logic [19:0] mag_1,
    input  logic [19:0] mag_2,
    input  logic [19:0] mag_3,
    input  logic [19:0] mag_4,
    input  logic        coef_wr,
    input  logic [2:0]  coef_addr,
    input  logic [17:0] coef_i,
    input  logic [17:0] coef_q,
    input  logic        coef_commit,
`ifdef DPD_POLY_BYPASS_EN
    input  logic        bypass,
`endif
    output logic [19:0] out_i,
    output logic [19:0] out_q,
    output logic        out_valid,
    output logic        out_sat,
    output logic        coef_err
);

    function automatic logic signed [19:0] sat20(input logic signed [40:0] r);
        if (r > 41'sd524287)       sat20 = 20'sh7FFFF;
        else if (r < -41'sd524288) sat20 = 20'sh80000;
        else                       sat20 = r[19:0];
    endfunction

    function automatic logic ovf20(input logic signed [40:0] r);
        ovf20 = (r > 41'sd524287) || (r < -41'sd524288);
    endfunction

    logic [19:0] mag [5];
    assign mag[0] = mag_0;
    assign mag[1] = mag_1;
    assign mag[2] = mag_2;
    assign mag[3] = mag_3;
    assign mag[4] = mag_4;

    // Alignment line
    logic signed [19:0] al_i_q [ALIGN_DLY], al_i_d [ALIGN_DLY];
    logic signed [19:0] al_q_q [ALIGN_DLY], al_q_d [ALIGN_DLY];
    logic               al_v_q [ALIGN_DLY], al_v_d [ALIGN_DLY];
    logic signed [19:0] xa_i, xa_q;

    // Pipeline stages
    logic signed [40:0] p_i_q [5], p_i_d [5], p_q_q [5], p_q_d [5];
    logic signed [19:0] b_i_q [5], b_i_d [5], b_q_q [5], b_q_d [5];
    logic signed [37:0] m_ii_q [5], m_ii_d [5], m_qq_q [5], m_qq_d [5];
    logic signed [37:0] m_iq_q [5], m_iq_d [5], m_qi_q [5], m_qi_d [5];
    logic               v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic signed [19:0] out_i_q, out_i_d, out_q_q, out_q_d;
    logic               out_valid_q, out_valid_d, out_sat_q, out_sat_d;
    logic signed [40:0] re, im, re_r, im_r;

    // Coefficient banks
    logic signed [17:0] sh_ci_q [5], sh_ci_d [5], sh_cq_q [5], sh_cq_d [5];
    logic signed [17:0] ac_ci_q [5], ac_ci_d [5], ac_cq_q [5], ac_cq_d [5];
    logic               coef_err_q, coef_err_d;

`ifdef DPD_POLY_BYPASS_EN
    logic signed [19:0] x1_i_q, x1_i_d, x1_q_q, x1_q_d;
    logic signed [19:0] x2_i_q, x2_i_d, x2_q_q, x2_q_d;
    logic signed [19:0] x3_i_q, x3_i_d, x3_q_q, x3_q_d;
`endif

    assign xa_i = al_i_q[ALIGN_DLY-1];
    assign xa_q = al_q_q[ALIGN_DLY-1];

    always_comb begin
        al_i_d[0] = sig_in_i;
        al_q_d[0] = sig_in_q;
        al_v_d[0] = in_valid;
        for (int unsigned i = 1; i < ALIGN_DLY; i++) begin
            al_i_d[i] = al_i_q[i-1];
            al_q_d[i] = al_q_q[i-1];
            al_v_d[i] = al_v_q[i-1];
        end

        v1_d        = al_v_q[ALIGN_DLY-1];
        v2_d        = v1_q;
        v3_d        = v2_q;
        out_valid_d = v3_q;

        re = '0;
        im = '0;
        for (int unsigned k = 0; k < 5; k++) begin
            // S1: magnitude is zero-extended so the product is signed
            p_i_d[k]  = xa_i * $signed({1'b0, mag[k]});
            p_q_d[k]  = xa_q * $signed({1'b0, mag[k]});
            // S2
            b_i_d[k]  = sat20((p_i_q[k] + 41'sd262144) >>> 19);
            b_q_d[k]  = sat20((p_q_q[k] + 41'sd262144) >>> 19);
            // S3
            m_ii_d[k] = b_i_q[k] * ac_ci_q[k];
            m_qq_d[k] = b_q_q[k] * ac_cq_q[k];
            m_iq_d[k] = b_i_q[k] * ac_cq_q[k];
            m_qi_d[k] = b_q_q[k] * ac_ci_q[k];
            // S4
            re = re + m_ii_q[k] - m_qq_q[k];
            im = im + m_iq_q[k] + m_qi_q[k];
        end
        re_r      = (re + 41'sd32768) >>> 16;
        im_r      = (im + 41'sd32768) >>> 16;
        out_i_d   = sat20(re_r);
        out_q_d   = sat20(im_r);
        out_sat_d = ovf20(re_r) | ovf20(im_r);

`ifdef DPD_POLY_BYPASS_EN
        x1_i_d = xa_i;
        x1_q_d = xa_q;
        x2_i_d = x1_i_q;
        x2_q_d = x1_q_q;
        x3_i_d = x2_i_q;
        x3_q_d = x2_q_q;
        if (bypass) begin
            out_i_d   = x3_i_q;
            out_q_d   = x3_q_q;
            out_sat_d = 1'b0;
        end
`endif

        // A write in the commit cycle is forwarded into the active bank
        for (int unsigned k = 0; k < 5; k++) begin
            sh_ci_d[k] = sh_ci_q[k];
            sh_cq_d[k] = sh_cq_q[k];
            if (coef_wr && (coef_addr == 3'(k))) begin
                sh_ci_d[k] = coef_i;
                sh_cq_d[k] = coef_q;
            end
            ac_ci_d[k] = coef_commit ? sh_ci_d[k] : ac_ci_q[k];
            ac_cq_d[k] = coef_commit ? sh_cq_d[k] : ac_cq_q[k];
        end
        coef_err_d = coef_err_q | (coef_wr & (coef_addr > 3'd4));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ALIGN_DLY; i++) begin
                al_i_q[i] <= '0;
                al_q_q[i] <= '0;
                al_v_q[i] <= 1'b0;
            end
            for (int unsigned k = 0; k < 5; k++) begin
                p_i_q[k]  <= '0;
                p_q_q[k]  <= '0;
                b_i_q[k]  <= '0;
                b_q_q[k]  <= '0;
                m_ii_q[k] <= '0;
                m_qq_q[k] <= '0;
                m_iq_q[k] <= '0;
                m_qi_q[k] <= '0;
                sh_ci_q[k] <= (k == 0) ? 18'sd65536 : '0;
                sh_cq_q[k] <= '0;
                ac_ci_q[k] <= (k == 0) ? 18'sd65536 : '0;
                ac_cq_q[k] <= '0;
            end
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
            coef_err_q  <= 1'b0;
`ifdef DPD_POLY_BYPASS_EN
            x1_i_q <= '0;
            x1_q_q <= '0;
            x2_i_q <= '0;
            x2_q_q <= '0;
            x3_i_q <= '0;
            x3_q_q <= '0;
`endif
        end else begin
            al_i_q      <= al_i_d;
            al_q_q      <= al_q_d;
            al_v_q      <= al_v_d;
            p_i_q       <= p_i_d;
            p_q_q       <= p_q_d;
            b_i_q       <= b_i_d;
            b_q_q       <= b_q_d;
            m_ii_q      <= m_ii_d;
            m_qq_q      <= m_qq_d;
            m_iq_q      <= m_iq_d;
            m_qi_q      <= m_qi_d;
            sh_ci_q     <= sh_ci_d;
            sh_cq_q     <= sh_cq_d;
            ac_ci_q     <= ac_ci_d;
            ac_cq_q     <= ac_cq_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            v3_q        <= v3_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            out_valid_q <= out_valid_d;
            out_sat_q   <= out_sat_d;
            coef_err_q  <= coef_err_d;
`ifdef DPD_POLY_BYPASS_EN
            x1_i_q <= x1_i_d;
            x1_q_q <= x1_q_d;
            x2_i_q <= x2_i_d;
            x2_q_q <= x2_q_d;
            x3_i_q <= x3_i_d;
            x3_q_q <= x3_q_d;
`endif
        end
    end

    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_valid = out_valid_q;
    assign out_sat   = out_sat_q;
    assign coef_err  = coef_err_q;

endmodule

// File: doc/dpd_poly_apply.md
# dpd_poly_apply

Downstream consumer of the magnitude-power stage in the DPD datapath. It takes the complex baseband sample and the five magnitude powers |x|^0..|x|^4, forms basis terms b_k = |x|^k·x, and multiplies each by a programmable complex coefficient c_k. It sums the five products into the predistorted complex output y = Σ c_k·b_k. Coefficients are written into a shadow bank and made active by an atomic commit, so the running stream never sees a partial update.

## Interface
- ALIGN_DLY, 4: cycles `sig_in_i/q` and `in_valid` are delayed internally to line up with `mag_0..mag_4`. Must equal the magnitude stage latency. Range 1..15.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample qualifier, same cycle as `sig_in_i/q`
- sig_in_i, sig_in_q  in  20  signed Q1.19 input sample, same samples fed to the magnitude stage
- mag_0..mag_4  in  20 each  unsigned Q1.19 magnitude powers, ALIGN_DLY cycles behind `sig_in`
- coef_wr  in  1  shadow-bank write strobe
- coef_addr  in  3  coefficient index 0..4
- coef_i, coef_q  in  18 each  signed Q2.16 coefficient
- coef_commit  in  1  single-cycle pulse: copy shadow bank to active bank
- out_i, out_q  out  20 each  signed Q1.19 predistorted output, registered
- out_valid  out  1  qualifier for `out_i/q`
- out_sat  out  1  output saturated this sample (I or Q)
- coef_err  out  1  sticky flag: write to `coef_addr` > 4; cleared only by reset

## Operation
- Alignment: `sig_in_i/q` and `in_valid` pass through an ALIGN_DLY-deep register line to give xa_i, xa_q and va.
- S1 basis products: p_k = xa·mag_k, signed 20 × zero-extended 21-bit, full-width 41-bit, registered.
- S2 basis round: b_k = (p_k + 2^18) >>> 19, then saturated to [-524288, 524287], registered.
- S3 coefficient products: four 20×18 signed products per k (bi·ci, bq·cq, bi·cq, bq·ci), 38-bit Q3.35, registered. Coefficients come from the active bank.
- S4 sum: re = Σ(bi·ci − bq·cq) and im = Σ(bi·cq + bq·ci), computed in 41-bit. Round by adding 2^15, arithmetic shift right 16, saturate to 20-bit signed. Register into `out_i/q`.
- `out_sat` is set when either component clipped at S4. It does not reflect S2 basis clipping.
- Valid handling:
  - `out_valid` is va delayed through S1..S4.
  - The datapath runs every cycle regardless of valid.
  - While `out_valid`=0 the output values are don't-care except after reset.
- Coefficient writes:
  - `coef_wr` with `coef_addr` 0..4 updates that shadow entry on the clock edge.
  - `coef_addr` 5..7 is ignored and sets `coef_err`.
- Commit:
  - `coef_commit` copies all five shadow entries to the active bank on the clock edge.
  - Write and commit in the same cycle: the written value is forwarded, so the active bank gets the new value.
  - Back-to-back commits are legal; each one copies again.
- Reset:
  - Both banks reset to identity: c_0 = 65536 + j0, c_1..c_4 = 0.
  - All pipeline registers, `out_i/q`, `out_valid`, `out_sat` and `coef_err` reset to 0.
  - Asserting reset mid-stream drops every in-flight sample. No `out_valid` appears for samples that entered before reset.

## Timing
- Latency from `mag_k` to `out_*` is 4 cycles.
- Latency from `sig_in` / `in_valid` to `out_*` is ALIGN_DLY + 4 cycles.
- Throughput is one sample per clock, with no stalls and no backpressure.
- A commit at edge T affects samples whose S3 stage is at edge T+1 or later.
- The first output using new coefficients is at most 2 cycles after the commit edge, measured at the `out_*` edge.
- A sample is never computed with a mixture of old and new coefficients, because the active bank is read once, in S3.
- `coef_err` rises on the edge after the bad write.

## Configuration
- DPD_POLY_BYPASS_EN defined:
  - Adds input port `bypass` (1 bit).
  - When `bypass`=1 at S4, `out_i/q` = xa delayed to the same ALIGN_DLY + 4 latency, and `out_sat`=0.
  - Toggling `bypass` creates no latency change and no gap in `out_valid`.
- DPD_POLY_BYPASS_EN undefined:
  - The port does not exist.
  - The output is always the polynomial result.

## Test plan
- Reset identity:
  - Stimulus: after reset, drive `sig_in` = 100000 − j50000 with valid, and `mag_0` = 524287, other `mag_k` = 0.
  - Required: `out_i/q` = 100000 / −50000 at ALIGN_DLY + 4 cycles, `out_valid`=1, `out_sat`=0.
- Single higher-order term:
  - Stimulus: commit c_0 = 0, c_2 = 32768 (0.5); drive x = 200000 + j0, `mag_2` = 262144 (0.5).
  - Required: `out_i` = 50000, `out_q` = 0.
- Saturation:
  - Stimulus: c_0 = 131071, x = 500000 + j500000, `mag_0` = 524287.
  - Required: `out_i` = `out_q` = 524287 and `out_sat`=1.
  - Repeat with x = −500000 − j500000: both outputs = −524288.
- Shadow/commit atomicity:
  - Stimulus: write c_0 = 0 while streaming, without commit.
  - Required: output is unchanged.
  - Stimulus: pulse `coef_commit` together with a write of c_1.
  - Required: output switches on a single sample boundary and uses the new c_1.
- Bad address and reset mid-stream:
  - Stimulus: write `coef_addr` = 6.
  - Required: `coef_err`=1, banks unchanged.
  - Stimulus: assert `rst_n` low for 1 cycle with samples in flight.
  - Required: `out_valid` stays 0 until ALIGN_DLY + 4 cycles after the next valid input; `coef_err` = 0.
- Bypass (with DPD_POLY_BYPASS_EN):
  - Stimulus: non-identity coefficients, toggle `bypass` each sample.
  - Required: alternate outputs equal the delayed x exactly, with a continuous `out_valid`.
